// File: rtl/stlb_plru_ctrl_pkg.sv
// Shared definitions for the STLB replacement/invalidation controller.
// Holds default geometry, derived index widths and the flush FSM state type.
package tlb_pkg;

  localparam int unsigned DEF_NSET  = 8;
  localparam int unsigned DEF_NWAY  = 8;
  localparam int unsigned DEF_SPCID = 12;

  localparam int unsigned SET_W = $clog2(DEF_NSET);
  localparam int unsigned WAY_W = $clog2(DEF_NWAY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/stlb_plru_ctrl_if.sv
// Bus between the lookup/fill pipeline (master) and the STLB replacement
// controller (slave).
//   hit_*      : lookup hit touch request
//   fill_*     : victim request / ready / ack with chosen way
//   flush_*    : flush start (pulse), mode, PCID, busy and done pulse
//   scan_set   : set currently walked by a flush, scan_pcid its way PCIDs
//   inv_en/inv_mask : invalidate strobe and way mask for scan_set
interface stlb_plru_ctrl_if #(
  parameter int unsigned NSET  = 8,
  parameter int unsigned NWAY  = 8,
  parameter int unsigned SPCID = 12
);
  localparam int unsigned SW = $clog2(NSET);
  localparam int unsigned WW = $clog2(NWAY);

  logic                  hit_valid;
  logic [SW-1:0]         hit_set;
  logic [WW-1:0]         hit_way;
  logic                  fill_req;
  logic [SW-1:0]         fill_set;
  logic                  fill_ready;
  logic                  fill_ack;
  logic [WW-1:0]         fill_way;
  logic                  flush_req;
  logic                  flush_all;
  logic [SPCID-1:0]      flush_pcid;
  logic                  flush_busy;
  logic                  flush_done;
  logic [SW-1:0]         scan_set;
  logic [NWAY*SPCID-1:0] scan_pcid;
  logic                  inv_en;
  logic [NWAY-1:0]       inv_mask;

  modport master (
    output hit_valid, hit_set, hit_way, fill_req, fill_set,
           flush_req, flush_all, flush_pcid, scan_pcid,
    input  fill_ready, fill_ack, fill_way, flush_busy, flush_done,
           scan_set, inv_en, inv_mask
  );

  modport slave (
    input  hit_valid, hit_set, hit_way, fill_req, fill_set,
           flush_req, flush_all, flush_pcid, scan_pcid,
    output fill_ready, fill_ack, fill_way, flush_busy, flush_done,
           scan_set, inv_en, inv_mask
  );
endinterface

// File: rtl/stlb_plru_ctrl_plru_tree.sv
// plru_tree: combinational tree-PLRU helper for one set.
//   plru_i       : node bits, node n has children 2n+1 / 2n+2, 1 = right
//   way_i        : way to touch
//   victim_o     : leaf reached by following the node bits from the root
//   touch_mask_o : nodes on the path to way_i
//   touch_val_o  : values making those nodes point away from way_i
// Touch is returned as mask/value so callers can merge several touches
// with a chosen precedence.
module plru_tree #(
  parameter int unsigned NWAY = 8,
  localparam int unsigned WW  = $clog2(NWAY)
) (
  input  logic [NWAY-2:0] plru_i,
  input  logic [WW-1:0]   way_i,
  output logic [WW-1:0]   victim_o,
  output logic [NWAY-2:0] touch_mask_o,
  output logic [NWAY-2:0] touch_val_o
);

  // Each followed bit is also the next way-index bit, MSB first.
  always_comb begin : victim_walk
    int unsigned n;
    n        = 0;
    victim_o = '0;
    for (int unsigned l = 0; l < WW; l++) begin
      victim_o[WW-1-l] = plru_i[n];
      n = 2*n + 1 + 32'(plru_i[n]);
    end
  end

  always_comb begin : touch_walk
    int unsigned n;
    logic        b;
    n            = 0;
    touch_mask_o = '0;
    touch_val_o  = '0;
    for (int unsigned l = 0; l < WW; l++) begin
      b               = way_i[WW-1-l];
      touch_mask_o[n] = 1'b1;
      touch_val_o[n]  = ~b;
      n = 2*n + 1 + 32'(b);
    end
  end

endmodule

// File: rtl/stlb_plru_ctrl.sv
// stlb_plru_ctrl: replacement and invalidation controller for STLB ways.
// Keeps per-set valid bits and tree-PLRU state, applies hit/fill touches,
// picks fill victims and walks all sets for PCID-selective/global flushes.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : stlb_plru_ctrl_if.slave (hit, fill, flush, scan/invalidate)
// Build option STLB_INVALID_FIRST_EN: prefer the lowest invalid way as the
// victim; without it the PLRU victim is always used.
module stlb_plru_ctrl
  import tlb_pkg::*;
#(
  parameter int unsigned NSET  = DEF_NSET,
  parameter int unsigned NWAY  = DEF_NWAY,
  parameter int unsigned SPCID = DEF_SPCID
) (
  input  logic              clk,
  input  logic              rst_n,
  stlb_plru_ctrl_if.slave   bus
);

  localparam int unsigned SW = $clog2(NSET);
  localparam int unsigned WW = $clog2(NWAY);
  localparam int unsigned NN = NWAY - 1;

  state_e           state_q, state_d;
  logic [SW-1:0]    scan_q, scan_d;
  logic             flush_all_q;
  logic [SPCID-1:0] flush_pcid_q;
  logic             ack_q;
  logic [WW-1:0]    way_q;
  logic [NN-1:0]    plru_q  [NSET];
  logic [NN-1:0]    plru_d  [NSET];
  logic [NWAY-1:0]  valid_q [NSET];
  logic [NWAY-1:0]  valid_d [NSET];

  logic             idle, hit_acc, fill_acc, flush_start;
  logic [WW-1:0]    plru_victim, fill_way_sel, hit_victim_unused;
  logic [NN-1:0]    hit_mask, hit_val, fill_mask, fill_val;
  logic [NWAY-1:0]  inv_mask;

  assign idle        = (state_q == IDLE);
  assign flush_start = idle & bus.flush_req;
  assign hit_acc     = idle & bus.hit_valid;
  assign fill_acc    = idle & bus.fill_req & ~bus.flush_req;

  plru_tree #(.NWAY(NWAY)) u_hit_tree (
    .plru_i       (plru_q[bus.hit_set]),
    .way_i        (bus.hit_way),
    .victim_o     (hit_victim_unused),
    .touch_mask_o (hit_mask),
    .touch_val_o  (hit_val)
  );

  plru_tree #(.NWAY(NWAY)) u_fill_tree (
    .plru_i       (plru_q[bus.fill_set]),
    .way_i        (fill_way_sel),
    .victim_o     (plru_victim),
    .touch_mask_o (fill_mask),
    .touch_val_o  (fill_val)
  );

`ifdef STLB_INVALID_FIRST_EN
  // Scan downwards so the lowest invalid way is the last one written.
  always_comb begin
    fill_way_sel = plru_victim;
    for (int unsigned w = NWAY; w > 0; w--) begin
      if (!valid_q[bus.fill_set][w-1]) fill_way_sel = WW'(w-1);
    end
  end
`else
  assign fill_way_sel = plru_victim;
`endif

  always_comb begin
    for (int unsigned w = 0; w < NWAY; w++) begin
      inv_mask[w] = (state_q == FLUSH) & valid_q[scan_q][w] &
                    (flush_all_q | (bus.scan_pcid[w*SPCID +: SPCID] == flush_pcid_q));
    end
  end

  // Hit touch is applied first and the fill touch on top of it, so the
  // fill path wins on shared nodes; the victim already came from plru_q.
  always_comb begin
    for (int unsigned s = 0; s < NSET; s++) begin
      plru_d[s]  = plru_q[s];
      valid_d[s] = valid_q[s];
    end
    if (hit_acc) begin
      plru_d[bus.hit_set] = (plru_q[bus.hit_set] & ~hit_mask) | hit_val;
    end
    if (fill_acc) begin
      plru_d[bus.fill_set] = (plru_d[bus.fill_set] & ~fill_mask) | fill_val;
      valid_d[bus.fill_set][fill_way_sel] = 1'b1;
    end
    if (state_q == FLUSH) begin
      valid_d[scan_q] = valid_q[scan_q] & ~inv_mask;
    end
  end

  always_comb begin
    state_d = state_q;
    scan_d  = scan_q;
    case (state_q)
      IDLE: begin
        if (bus.flush_req) begin
          state_d = FLUSH;
          scan_d  = '0;
        end
      end
      FLUSH: begin
        if (scan_q == SW'(NSET-1)) begin
          state_d = DONE;
          scan_d  = '0;
        end else begin
          scan_d = scan_q + SW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      scan_q       <= '0;
      flush_all_q  <= 1'b0;
      flush_pcid_q <= '0;
      ack_q        <= 1'b0;
      way_q        <= '0;
      for (int unsigned s = 0; s < NSET; s++) begin
        plru_q[s]  <= '0;
        valid_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
      ack_q   <= fill_acc;
      if (fill_acc) way_q <= fill_way_sel;
      if (flush_start) begin
        flush_all_q  <= bus.flush_all;
        flush_pcid_q <= bus.flush_pcid;
      end
      plru_q  <= plru_d;
      valid_q <= valid_d;
    end
  end

  assign bus.fill_ready = idle;
  assign bus.fill_ack   = ack_q;
  assign bus.fill_way   = way_q;
  assign bus.flush_busy = (state_q == FLUSH);
  assign bus.flush_done = (state_q == DONE);
  assign bus.scan_set   = scan_q;
  assign bus.inv_en     = (state_q == FLUSH);
  assign bus.inv_mask   = inv_mask;

endmodule
